// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter sharing one 4-digit seven-segment display between NREQ requesters.
// Each accepted value is saturated to 9999, converted to BCD by double-dabble and held for a dwell time.
module seg_display_arbiter #(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned DWELL_CYCLES = 50_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [32*NREQ-1:0]      req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    hold,
  output logic [15:0]             disp_bcd,
  output logic [3:0]              disp_blank,
  output logic                    disp_ovf,
  output logic [$clog2(NREQ)-1:0] disp_owner,
  output logic                    busy
);

  localparam int unsigned      OW         = $clog2(NREQ);
  localparam logic [31:0]      DWELL_LOAD = 32'(DWELL_CYCLES - 1);
  localparam logic [OW-1:0]    LAST_RST   = OW'(NREQ - 1);
  localparam logic [3:0]       ITER_LAST  = 4'd13;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    SHOW
  } state_t;

  state_t        state_q, state_d;
  logic [OW-1:0] last_owner_q, last_owner_d;
  logic [29:0]   shreg_q, shreg_d;
  logic [3:0]    iter_q, iter_d;
  logic          ovf_pend_q, ovf_pend_d;
  logic [OW-1:0] owner_pend_q, owner_pend_d;
  logic [31:0]   dwell_q, dwell_d;
  logic [15:0]   bcd_q, bcd_d;
  logic [3:0]    blank_q, blank_d;
  logic          ovf_q, ovf_d;
  logic [OW-1:0] owner_q, owner_d;

  logic          grant_valid;
  logic [OW-1:0] grant_idx;
  logic [31:0]   sel_data;
  logic [13:0]   sat_val;
  logic          sat_ovf;
  logic [29:0]   dd_next;

  // One double-dabble iteration on {bcd[15:0], binary[13:0]}: adjust nibbles, then shift.
  function automatic logic [29:0] dd_step(input logic [29:0] v);
    logic [29:0] a;
    a = v;
    for (int unsigned k = 0; k < 4; k++) begin
      if (a[14 + 4*k +: 4] >= 4'd5) begin
        a[14 + 4*k +: 4] = a[14 + 4*k +: 4] + 4'd3;
      end
    end
    return {a[28:0], 1'b0};
  endfunction

  function automatic logic [3:0] blank_of(input logic [15:0] b);
    logic z3, z2, z1;
    z3 = (b[15:12] == 4'd0);
    z2 = z3 && (b[11:8] == 4'd0);
    z1 = z2 && (b[7:4] == 4'd0);
    return {z3, z2, z1, 1'b0};
  endfunction

  // Search last_owner+1 .. last_owner+NREQ (mod NREQ); first valid index wins.
  always_comb begin : rr_search
    int unsigned cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    sel_data    = '0;
    cand        = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = 32'(last_owner_q) + i;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      if (!grant_valid && req_valid[cand[OW-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[OW-1:0];
        sel_data    = req_data[32*cand +: 32];
      end
    end
  end

  assign sat_ovf = (sel_data > 32'd9999);
  assign sat_val = sat_ovf ? 14'd9999 : sel_data[13:0];
  assign dd_next = dd_step(shreg_q);

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    shreg_d      = shreg_q;
    iter_d       = iter_q;
    ovf_pend_d   = ovf_pend_q;
    owner_pend_d = owner_pend_q;
    dwell_d      = dwell_q;
    bcd_d        = bcd_q;
    blank_d      = blank_q;
    ovf_d        = ovf_q;
    owner_d      = owner_q;
    req_ready    = '0;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          req_ready[grant_idx] = 1'b1;
          shreg_d              = {16'd0, sat_val};
          ovf_pend_d           = sat_ovf;
          owner_pend_d         = grant_idx;
          last_owner_d         = grant_idx;
          iter_d               = '0;
          state_d              = CONVERT;
        end
      end
      CONVERT: begin
        shreg_d = dd_next;
        iter_d  = iter_q + 4'd1;
        // Display registers load straight from the final iteration so partial BCD never leaks out.
        if (iter_q == ITER_LAST) begin
          bcd_d   = dd_next[29:14];
          blank_d = blank_of(dd_next[29:14]);
          ovf_d   = ovf_pend_q;
          owner_d = owner_pend_q;
          dwell_d = DWELL_LOAD;
          iter_d  = '0;
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (!hold) begin
          if (dwell_q == 32'd0) begin
            state_d = IDLE;
          end else begin
            dwell_d = dwell_q - 32'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= LAST_RST;
      shreg_q      <= '0;
      iter_q       <= '0;
      ovf_pend_q   <= 1'b0;
      owner_pend_q <= '0;
      dwell_q      <= '0;
      bcd_q        <= '0;
      blank_q      <= 4'b1110;
      ovf_q        <= 1'b0;
      owner_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      shreg_q      <= shreg_d;
      iter_q       <= iter_d;
      ovf_pend_q   <= ovf_pend_d;
      owner_pend_q <= owner_pend_d;
      dwell_q      <= dwell_d;
      bcd_q        <= bcd_d;
      blank_q      <= blank_d;
      ovf_q        <= ovf_d;
      owner_q      <= owner_d;
    end
  end

  assign disp_bcd   = bcd_q;
  assign disp_blank = blank_q;
  assign disp_ovf   = ovf_q;
  assign disp_owner = owner_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter (NREQ=4, DWELL_CYCLES=4) with hand-computed expectations.
module tb_seg_display_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         hold;
  logic [15:0]  disp_bcd;
  logic [3:0]   disp_blank;
  logic         disp_ovf;
  logic [1:0]   disp_owner;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  seg_display_arbiter #(
    .NREQ         (4),
    .DWELL_CYCLES (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .hold       (hold),
    .disp_bcd   (disp_bcd),
    .disp_blank (disp_blank),
    .disp_ovf   (disp_ovf),
    .disp_owner (disp_owner),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_bcd"},   32'(disp_bcd),   32'h0);
    check_eq({tag, "_blank"}, 32'(disp_blank), 32'hE);
    check_eq({tag, "_ovf"},   32'(disp_ovf),   32'h0);
    check_eq({tag, "_owner"}, 32'(disp_owner), 32'h0);
    check_eq({tag, "_busy"},  32'(busy),       32'h0);
    check_eq({tag, "_ready"}, 32'(req_ready),  32'h0);
  endtask

  // One full transaction: request idx (plus pend_mask lanes), accept, convert, show.
  task automatic show_value(input int idx, input logic [31:0] data,
                            input logic [15:0] exp_bcd, input logic [3:0] exp_blank,
                            input logic exp_ovf, input logic [15:0] prev_bcd,
                            input int hold_lo, input int hold_hi, input int exp_busy,
                            input logic [3:0] pend_mask);
    int n;
    int leak;
    logic [3:0] exp_rdy;
    n    = 1;
    leak = 0;
    @(negedge clk);
    req_data[32*idx +: 32] = data;
    req_valid[idx]         = 1'b1;
    req_valid              = req_valid | pend_mask;
    #1;
    exp_rdy      = '0;
    exp_rdy[idx] = 1'b1;
    check_eq("ready_grant", 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
    req_valid[idx] = 1'b0;
    check_eq("ready_after_accept", 32'(req_ready), 32'h0);
    check_eq("busy_after_accept", 32'(busy), 32'h1);
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      hold = (k >= hold_lo) && (k <= hold_hi);
      @(posedge clk);
      #1;
      if (k == 13) check_eq("bcd_before_update", 32'(disp_bcd), 32'(prev_bcd));
      if (k == 14) begin
        check_eq("bcd", 32'(disp_bcd), 32'(exp_bcd));
        check_eq("blank", 32'(disp_blank), 32'(exp_blank));
        check_eq("ovf", 32'(disp_ovf), 32'(exp_ovf));
        check_eq("owner", 32'(disp_owner), 32'(idx));
      end
      if (!busy) break;
      if (req_ready != 4'b0000) leak++;
      n++;
    end
    hold = 1'b0;
    check_eq("busy_cycles", 32'(n), 32'(exp_busy));
    check_eq("ready_while_busy", 32'(leak), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_order[6];
    int grants;
    int multi;
    int got_idx;
    int cyc;
    exp_order = '{0, 1, 2, 3, 0, 1};

    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    hold      = 1'b0;
    #1;
    check_reset_values("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic transaction and edge values
    show_value(0, 32'd1234,       16'h1234, 4'b0000, 1'b0, 16'h0000, 0, -1, 18, 4'b0000);
    show_value(1, 32'd7,          16'h0007, 4'b1110, 1'b0, 16'h1234, 0, -1, 18, 4'b0000);
    show_value(2, 32'd0,          16'h0000, 4'b1110, 1'b0, 16'h0007, 0, -1, 18, 4'b0000);
    show_value(3, 32'd10000,      16'h9999, 4'b0000, 1'b1, 16'h0000, 0, -1, 18, 4'b0000);
    show_value(0, 32'hFFFF_FFFF,  16'h9999, 4'b0000, 1'b1, 16'h9999, 0, -1, 18, 4'b0000);
    show_value(1, 32'd9999,       16'h9999, 4'b0000, 1'b0, 16'h9999, 0, -1, 18, 4'b0000);
    show_value(2, 32'd305,        16'h0305, 4'b1000, 1'b0, 16'h9999, 0, -1, 18, 4'b0000);
    show_value(3, 32'd42,         16'h0042, 4'b1100, 1'b0, 16'h0305, 0, -1, 18, 4'b0000);
    show_value(0, 32'd5000,       16'h5000, 4'b0000, 1'b0, 16'h0042, 0, -1, 18, 4'b0000);

    // Hold for 10 SHOW cycles while requester 2 waits; it is granted only afterwards
    req_data[64 +: 32] = 32'd66;
    show_value(1, 32'd55, 16'h0055, 4'b1100, 1'b0, 16'h5000, 15, 24, 28, 4'b0100);
    show_value(2, 32'd66, 16'h0066, 4'b1100, 1'b0, 16'h0055, 0, -1, 18, 4'b0000);

    // Reset during CONVERT discards the conversion
    @(negedge clk);
    req_data[96 +: 32] = 32'd4321;
    req_valid[3]       = 1'b1;
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_values("rst_convert");
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_eq("post_rst_bcd", 32'(disp_bcd), 32'h0);
    check_eq("post_rst_blank", 32'(disp_blank), 32'hE);
    check_eq("post_rst_busy", 32'(busy), 32'h0);

    // Round robin with all four requesters valid
    for (int i = 0; i < 4; i++) req_data[32*i +: 32] = 32'(1111 * (i + 1));
    grants = 0;
    multi  = 0;
    cyc    = 0;
    @(negedge clk);
    req_valid = 4'b1111;
    while (grants < 6 && cyc < 400) begin
      #1;
      if ((req_ready & (req_ready - 4'd1)) != 4'd0) multi++;
      if (req_ready != 4'd0) begin
        got_idx = -1;
        for (int j = 0; j < 4; j++) if (req_ready[j]) got_idx = j;
        check_eq("rr_order", 32'(got_idx), 32'(exp_order[grants]));
        grants++;
        if (grants == 6) break;
      end
      cyc++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    check_eq("rr_grants", 32'(grants), 32'd6);
    check_eq("rr_multihot", 32'(multi), 32'd0);
    for (int k = 0; k < 100; k++) begin
      if (!busy) break;
      @(posedge clk);
      #1;
    end
    check_eq("rr_idle", 32'(busy), 32'h0);
    check_eq("rr_last_owner", 32'(disp_owner), 32'd1);
    check_eq("rr_last_bcd", 32'(disp_bcd), 32'h2222);

    // Asynchronous reset with no clock edge
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    @(negedge clk);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
